// File: rtl/hit_point.sv
// hit_point: computes P = O + t*D in Q-format fixed point for a divider-fed ray parameter t,
// one axis per cycle on a shared multiplier, with a valid/ready result and one result per t_valid pulse.
module hit_point #(
    parameter int Q_BITS  = 10,
    parameter int D_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] t_in,
    input  logic               t_valid,
    input  logic [D_WIDTH-1:0] t_max,
    input  logic [D_WIDTH-1:0] ox,
    input  logic [D_WIDTH-1:0] oy,
    input  logic [D_WIDTH-1:0] oz,
    input  logic [D_WIDTH-1:0] dx,
    input  logic [D_WIDTH-1:0] dy,
    input  logic [D_WIDTH-1:0] dz,
    output logic [D_WIDTH-1:0] px,
    output logic [D_WIDTH-1:0] py,
    output logic [D_WIDTH-1:0] pz,
    output logic               hit,
    output logic               valid_out,
    input  logic               out_ready
);
    typedef enum logic [2:0] {IDLE, MX, MY, MZ, OUT, REARM} state_t;
    localparam logic signed [2*D_WIDTH-1:0] HALF = (2*D_WIDTH)'(1) << (Q_BITS - 1);
    state_t state, state_next;
    logic [D_WIDTH-1:0] t_r, ox_r, oy_r, oz_r, dx_r, dy_r, dz_r, d_sel, o_sel, axis;
    logic signed [2*D_WIDTH-1:0] prod;
    logic in_hit;
    assign in_hit = ($signed(t_in) > 0) && ($signed(t_in) <= $signed(t_max));
    always_comb begin
        d_sel = state == MY ? dy_r : state == MZ ? dz_r : dx_r;
        o_sel = state == MY ? oy_r : state == MZ ? oz_r : ox_r;
        // sign-extend both operands so the low 2*D_WIDTH bits are the signed product
        prod = {{D_WIDTH{t_r[D_WIDTH-1]}}, t_r} * {{D_WIDTH{d_sel[D_WIDTH-1]}}, d_sel};
        axis = D_WIDTH'((prod + HALF) >>> Q_BITS) + o_sel;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = t_valid ? (in_hit ? MX : OUT) : IDLE;
            MX:      state_next = MY;
            MY:      state_next = MZ;
            MZ:      state_next = OUT;
            OUT:     state_next = (valid_out && out_ready) ? REARM : OUT;
            REARM:   state_next = t_valid ? REARM : IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            {t_r, ox_r, oy_r, oz_r, dx_r, dy_r, dz_r} <= '0;
            {px, py, pz} <= '0;
            hit       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && t_valid) begin
                {t_r, ox_r, oy_r, oz_r, dx_r, dy_r, dz_r} <= {t_in, ox, oy, oz, dx, dy, dz};
                hit <= in_hit;
                {px, py, pz} <= '0;
            end
            if (state == MX) px <= axis;
            if (state == MY) py <= axis;
            if (state == MZ) pz <= axis;
            // valid rises one cycle after entering OUT and drops on the accepting edge
            valid_out <= (state == OUT) && !(valid_out && out_ready);
        end
    end
endmodule

// File: tb/tb_hit_point.sv
// tb_hit_point: directed and randomized rays checked against an arithmetic reference model.
module tb_hit_point;
    logic clock = 0, reset = 0, t_valid = 0, out_ready = 0;
    logic [31:0] t_in = 0, t_max = 0, ox = 0, oy = 0, oz = 0, dx = 0, dy = 0, dz = 0;
    logic [31:0] px, py, pz;
    logic hit, valid_out;
    int tests = 0, fails = 0;

    hit_point #(.Q_BITS(10), .D_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .t_in(t_in), .t_valid(t_valid), .t_max(t_max),
        .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
        .px(px), .py(py), .pz(pz), .hit(hit), .valid_out(valid_out), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int axis_ref(input int t, input int d, input int o);
        longint p;
        p = longint'(t) * longint'(d);
        p = (p + 512) >>> 10;
        return int'(p) + o;
    endfunction

    task automatic txn(input int t, input int tm, input int o[3], input int d[3],
                       input int stall, input int hold);
        bit eh;
        int ep[3];
        int lat;
        logic [31:0] sx, sy, sz;
        eh = (t > 0) && (t <= tm);
        for (int i = 0; i < 3; i++) ep[i] = eh ? axis_ref(t, d[i], o[i]) : 0;
        @(negedge clock);
        t_in = t; t_max = tm; ox = o[0]; oy = o[1]; oz = o[2]; dx = d[0]; dy = d[1]; dz = d[2];
        t_valid = 1; out_ready = 0;
        @(posedge clock);
        #1;
        {t_in, t_max, ox, oy, oz, dx, dy, dz} = {$urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom, $urandom, $urandom};
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!valid_out && lat < 20);
        check("latency", lat, eh ? 4 : 1);
        check("hit", hit, eh);
        check("px", $signed(px), ep[0]);
        check("py", $signed(py), ep[1]);
        check("pz", $signed(pz), ep[2]);
        {sx, sy, sz} = {px, py, pz};
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            check("stall_valid", valid_out, 1);
            check("stall_p", {px, py, pz} == {sx, sy, sz}, 1);
        end
        @(negedge clock);
        out_ready = 1;
        @(posedge clock);
        #1;
        check("accept_clear", valid_out, 0);
        @(negedge clock);
        out_ready = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("held_t_valid", valid_out, 0);
        end
        @(negedge clock);
        t_valid = 0;
        @(posedge clock);
    endtask

    initial begin
        int o[3], d[3];
        t_valid = 1; t_in = 2048; t_max = 10240;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_hit", hit, 0);
        check("rst_p", {px, py, pz}, 0);
        @(negedge clock);
        t_valid = 0; reset = 1;
        @(posedge clock);

        txn(2048, 10240, '{1024, 0, -512}, '{1024, 512, 0}, 0, 0);
        txn(-1024, 10240, '{1024, 0, -512}, '{1024, 512, 0}, 0, 0);
        txn(5120, 5120, '{7, -7, 100}, '{-2048, 4096, 1}, 0, 0);
        txn(0, 5120, '{7, -7, 100}, '{-2048, 4096, 1}, 0, 0);
        txn(5121, 5120, '{7, -7, 100}, '{-2048, 4096, 1}, 0, 0);
        txn(512, 10240, '{0, 0, 0}, '{3, -3, 1}, 0, 0);
        txn(2048, 10240, '{1024, 0, -512}, '{1024, 512, 0}, 5, 20);

        @(negedge clock);
        t_in = 2048; t_max = 10240; ox = 1024; oy = 0; oz = -512; dx = 1024; dy = 512; dz = 0;
        t_valid = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        check("midrst_valid", valid_out, 0);
        check("midrst_hit", hit, 0);
        check("midrst_p", {px, py, pz}, 0);
        @(negedge clock);
        reset = 1; t_valid = 0;
        @(posedge clock);
        #1;
        check("post_rst_idle", valid_out, 0);
        txn(2048, 10240, '{1024, 0, -512}, '{1024, 512, 0}, 1, 2);

        for (int n = 0; n < 40; n++) begin
            int t, tm;
            for (int i = 0; i < 3; i++) begin
                o[i] = $urandom;
                d[i] = (n % 2) ? int'($urandom) : int'($urandom_range(0, 65535)) - 32768;
            end
            t = int'($urandom_range(0, 40000)) - 8000;
            tm = (n % 5 == 0) ? t : int'($urandom_range(0, 30000));
            txn(t, tm, o, d, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hit_point.md
HIT_POINT -- requirements
Module: hit_point

Interface
REQ-001 SHALL have parameter Q_BITS, default 10, fractional bits of all fixed-point operands.
REQ-002 SHALL have parameter D_WIDTH, default 32, width of every signed data port.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the clock rising edge.
REQ-005 SHALL have port t_in  input  D_WIDTH  signed ray parameter t, driven from the divider quotient.
REQ-006 SHALL have port t_valid  input  1  level valid from the divider; may stay high indefinitely.
REQ-007 SHALL have port t_max  input  D_WIDTH  signed upper bound for an accepted t.
REQ-008 SHALL have ports ox, oy, oz  input  D_WIDTH each  signed ray origin.
REQ-009 SHALL have ports dx, dy, dz  input  D_WIDTH each  signed ray direction.
REQ-010 SHALL have ports px, py, pz  output  D_WIDTH each  signed hit point.
REQ-011 SHALL have port hit  output  1  high when t is in range (0, t_max].
REQ-012 SHALL have port valid_out  output  1  result valid, held until accepted.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the result when it is high together with valid_out.

Function
REQ-014 SHALL implement states IDLE, MX, MY, MZ, OUT and REARM.
REQ-015 In IDLE with t_valid=1, SHALL capture t_in, t_max, origin and direction into registers on that edge.
REQ-016 On that same capture edge, SHALL register hit = (t_in > 0) && (t_in <= t_max), as a signed compare.
REQ-017 After capture, SHALL go to MX if hit=1, else directly to OUT with px=py=pz=0.
REQ-018 MX, MY and MZ SHALL each take one cycle and compute one axis in order x, y, z, reusing a single multiplier.
REQ-019 Per-axis arithmetic SHALL be:
- full 2*D_WIDTH signed product t*d;
- add 2^(Q_BITS-1);
- arithmetic shift right by Q_BITS;
- truncate to D_WIDTH;
- add the origin component with two's-complement wrap and no saturation.
REQ-020 Latency SHALL be 4 cycles from the capture edge to valid_out=1 on a hit, and 1 cycle on a miss.
REQ-021 In OUT, SHALL hold valid_out=1, hit, px, py and pz stable until a cycle with out_ready=1.
REQ-022 On the OUT edge with out_ready=1, SHALL clear valid_out and go to REARM.
REQ-023 In REARM, SHALL wait for t_valid=0 and then go to IDLE, so a held-high t_valid yields exactly one result.
REQ-024 SHALL ignore t_valid and all data inputs in every state except IDLE.
REQ-025 In IDLE, SHALL hold valid_out=0 and keep the previous px, py, pz and hit values.
REQ-026 t_in = t_max SHALL count as a hit; t_in = 0 and negative t_in SHALL count as misses.

Reset
REQ-027 With reset=0 at a rising edge, SHALL go to IDLE and clear valid_out, hit, px, py, pz and all internal registers to 0.
REQ-028 Reset SHALL take effect from any state, including MX to MZ and OUT.
REQ-029 After reset, SHALL produce no stale result and accept a new t only once reset=1 and the block is in IDLE.
REQ-030 Reset SHALL take priority over t_valid on the same edge.

Verification
REQ-031 Hit with t=2048 (2.0), O=(1024,0,-512), D=(1024,512,0), t_max=10240 and out_ready=1 -> valid_out 4 cycles after capture, hit=1, P=(3072,1024,-512).
REQ-032 Miss with t=-1024 -> valid_out 1 cycle after capture, hit=0, P=(0,0,0). With t=t_max=5120 -> hit=1.
REQ-033 Rounding check with t=512 (0.5), D=(3,-3,1), O=0 -> P=(2,-1,1), i.e. round half up after the shift.
REQ-034 Stall with out_ready held 0 for 5 cycles in OUT -> valid_out and P stable throughout; then exactly one accept cycle.
REQ-035 Held-high t_valid kept at 1 for 20 cycles after the accept -> no second valid_out. t_valid 0 then 1 -> one new result.
REQ-036 Reset (reset=0) asserted during MY -> next cycle IDLE with all outputs 0. A following t input -> correct result with normal latency.
